// File: rtl/systolic_pkg.sv
// Types and defaults shared between the skewed feeder and the systolic array it drives.
package systolic_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } feeder_state_t;

  localparam int N_CH_DEFAULT  = 4;
  localparam int DEPTH_DEFAULT = 7;
  localparam int DW_DEFAULT    = 8;

  // Beat counter must reach DEPTH+N_CH-2; never narrower than one bit.
  function automatic int cnt_width(input int depth, input int n_ch);
    return (depth + n_ch - 1 > 1) ? $clog2(depth + n_ch - 1) : 1;
  endfunction

endpackage

// File: rtl/skewed_feeder_if.sv
// Tile-load handshake and skewed stream outputs of the feeder, bundled for port use.
interface skewed_feeder_if
  import systolic_pkg::*;
#(
  parameter int N_CH  = N_CH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int DW    = DW_DEFAULT
);

  logic                        load_valid;
  logic                        load_ready;
  logic [N_CH*DEPTH*DW-1:0]    load_data;
  logic                        advance;
  logic signed [N_CH*DW-1:0]   data_out;
  logic [N_CH-1:0]             out_valid;
  logic                        busy;
  logic                        done;

  modport master (
    output load_valid, load_data, advance,
    input  load_ready, data_out, out_valid, busy, done
  );

  modport slave (
    input  load_valid, load_data, advance,
    output load_ready, data_out, out_valid, busy, done
  );

endinterface

// File: rtl/feeder_lane.sv
// One channel of the feeder: holds the active tile row and emits element cnt-R
// while that index lies inside the row, zero otherwise.
module feeder_lane
  import systolic_pkg::*;
#(
  parameter int R     = 0,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int DW    = DW_DEFAULT,
  parameter int CW    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  logic [DEPTH*DW-1:0] tile_i,
  input  logic                stream_i,
  input  logic [CW-1:0]       cnt_i,
  output logic [DW-1:0]       data_o,
  output logic                valid_o
);

  localparam int KW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] active_q [DEPTH];
  int            k;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) active_q[i] <= '0;
    end else if (load_i) begin
      for (int i = 0; i < DEPTH; i++) active_q[i] <= tile_i[i*DW +: DW];
    end
  end

  // Output depends only on registered count/state/storage, never on inputs.
  always_comb begin
    data_o  = '0;
    valid_o = 1'b0;
    k       = int'(cnt_i) - R;
    if (stream_i && (k >= 0) && (k < DEPTH)) begin
      data_o  = active_q[k[KW-1:0]];
      valid_o = 1'b1;
    end
  end

endmodule

// File: rtl/skewed_feeder.sv
// Double-buffered tile feeder: a shadow tile waits while the active tile streams
// out with channel r delayed by r beats; back-to-back tiles stream with no bubble.
module skewed_feeder
  import systolic_pkg::*;
#(
  parameter int N_CH  = N_CH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int DW    = DW_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  skewed_feeder_if.slave bus
);

  localparam int              CW     = cnt_width(DEPTH, N_CH);
  localparam int              LANE_W = DEPTH * DW;
  localparam int              TILE_W = N_CH * LANE_W;
  localparam logic [CW-1:0]   LAST   = CW'(DEPTH + N_CH - 2);

  feeder_state_t     state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TILE_W-1:0] shadow_q;
  logic              shadow_full_q, shadow_full_d;
  logic              accept, xfer, done_c, stream;
  logic [N_CH*DW-1:0] data_w;
  logic [N_CH-1:0]    valid_w;

  assign accept = bus.load_valid && !shadow_full_q;
  assign stream = (state_q == STREAM);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xfer    = 1'b0;
    done_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (shadow_full_q) begin
          xfer    = 1'b1;
          cnt_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (bus.advance) begin
          if (cnt_q == LAST) begin
            done_c = 1'b1;
            cnt_d  = '0;
            // A pending tile takes over on the same edge, so streaming never gaps.
            if (shadow_full_q) xfer = 1'b1;
            else               state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Transfer and accept are exclusive: accept needs an empty shadow, transfer a full one.
    shadow_full_d = xfer ? 1'b0 : (accept ? 1'b1 : shadow_full_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shadow_full_q <= shadow_full_d;
      if (accept) shadow_q <= bus.load_data;
    end
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_lane
      feeder_lane #(
        .R     (gi),
        .DEPTH (DEPTH),
        .DW    (DW),
        .CW    (CW)
      ) u_lane (
        .clk      (clk),
        .reset    (reset),
        .load_i   (xfer),
        .tile_i   (shadow_q[gi*LANE_W +: LANE_W]),
        .stream_i (stream),
        .cnt_i    (cnt_q),
        .data_o   (data_w[gi*DW +: DW]),
        .valid_o  (valid_w[gi])
      );
    end
  endgenerate

  assign bus.load_ready = !shadow_full_q;
  assign bus.data_out   = data_w;
  assign bus.out_valid  = valid_w;
  assign bus.busy       = stream;
  assign bus.done       = done_c;

endmodule

// File: tb/tb_skewed_feeder.sv
// Directed bench for skewed_feeder: single, back-to-back, stalled, over-offered,
// reset-aborted and negative-valued tiles, checked beat by beat.
module tb_skewed_feeder;
  import systolic_pkg::*;

  localparam int N_CH  = 4;
  localparam int DEPTH = 7;
  localparam int DW    = 8;
  localparam int BEATS = DEPTH + N_CH - 1;

  typedef logic [N_CH*DEPTH*DW-1:0] tile_t;
  typedef logic [N_CH*DW-1:0]       row_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  skewed_feeder_if #(.N_CH(N_CH), .DEPTH(DEPTH), .DW(DW)) bus ();

  skewed_feeder #(.N_CH(N_CH), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic tile_t mk_tile(input int base);
    tile_t t = '0;
    for (int r = 0; r < N_CH; r++)
      for (int k = 0; k < DEPTH; k++)
        t[(r*DEPTH+k)*DW +: DW] = DW'(base + 16*r + k);
    return t;
  endfunction

  function automatic row_t exp_data(input tile_t t, input int b);
    row_t d = '0;
    for (int r = 0; r < N_CH; r++) begin
      int k = b - r;
      if (k >= 0 && k < DEPTH) d[r*DW +: DW] = t[(r*DEPTH+k)*DW +: DW];
    end
    return d;
  endfunction

  function automatic logic [N_CH-1:0] exp_valid(input int b);
    logic [N_CH-1:0] v = '0;
    for (int r = 0; r < N_CH; r++) begin
      int k = b - r;
      v[r] = (k >= 0 && k < DEPTH);
    end
    return v;
  endfunction

  task automatic check_beat(input string tag, input tile_t t, input int b, input bit exp_ready);
    chk($sformatf("%s_b%0d_data", tag, b), 64'($unsigned(bus.data_out)), 64'(exp_data(t, b)));
    chk($sformatf("%s_b%0d_valid", tag, b), 64'(bus.out_valid), 64'(exp_valid(b)));
    chk($sformatf("%s_b%0d_busy", tag, b), 64'(bus.busy), 64'(1));
    chk($sformatf("%s_b%0d_done", tag, b), 64'(bus.done), 64'((b == BEATS-1) && bus.advance));
    chk($sformatf("%s_b%0d_ready", tag, b), 64'(bus.load_ready), 64'(exp_ready));
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_busy"},  64'(bus.busy), 64'(0));
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, "_data"},  64'($unsigned(bus.data_out)), 64'(0));
    chk({tag, "_done"},  64'(bus.done), 64'(0));
  endtask

  // Offer a tile from IDLE; returns with beat 0 of that tile visible.
  task automatic load_tile(input string tag, input tile_t t);
    bus.load_valid = 1'b1;
    bus.load_data  = t;
    chk({tag, "_ready_before"}, 64'(bus.load_ready), 64'(1));
    tick();
    bus.load_valid = 1'b0;
    chk({tag, "_ready_full"}, 64'(bus.load_ready), 64'(0));
    chk({tag, "_busy_pre"},   64'(bus.busy), 64'(0));
    tick();
  endtask

  // Called with beat 0 visible. Optionally offers a tile at beat 0 (accepted on the
  // first edge), optionally keeps offering a further tile, stalls, or aborts by reset.
  task automatic stream_tile(input string tag, input tile_t t,
                             input int stall_beat, input int stall_len,
                             input bit offer, input tile_t offer_tile,
                             input bit keep_offer, input tile_t keep_tile,
                             input int abort_beat,
                             input int lit_beat, input int lit_ch, input int lit_val);
    int sv;
    for (int b = 0; b < BEATS; b++) begin
      if (b == 0 && offer) begin
        bus.load_valid = 1'b1;
        bus.load_data  = offer_tile;
      end
      if (b == abort_beat) begin
        reset          = 1'b1;
        bus.load_valid = 1'b0;
        #1;
        chk({tag, "_rst_data"},  64'($unsigned(bus.data_out)), 64'(0));
        chk({tag, "_rst_valid"}, 64'(bus.out_valid), 64'(0));
        chk({tag, "_rst_ready"}, 64'(bus.load_ready), 64'(1));
        chk({tag, "_rst_busy"},  64'(bus.busy), 64'(0));
        chk({tag, "_rst_done"},  64'(bus.done), 64'(0));
        return;
      end
      check_beat(tag, t, b, !(offer && b > 0));
      if (b == lit_beat) begin
        sv = int'($signed(bus.data_out[lit_ch*DW +: DW]));
        chk($sformatf("%s_lit_b%0d_ch%0d", tag, b, lit_ch), 64'(sv), 64'(lit_val));
      end
      if (b == stall_beat) begin
        bus.advance = 1'b0;
        #1;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          check_beat($sformatf("%s_stall%0d", tag, s), t, b, !(offer && b > 0));
        end
        bus.advance = 1'b1;
        #1;
      end
      tick();
      if (b == 0 && offer) begin
        if (keep_offer) bus.load_data  = keep_tile;
        else            bus.load_valid = 1'b0;
      end
    end
  endtask

  initial begin
    tile_t ta, tbb, tc, td, zt;
    ta  = mk_tile(0);
    tbb = mk_tile(8'h08);
    tc  = mk_tile(8'h40);
    td  = mk_tile(8'h80);
    td[(1*DEPTH+6)*DW +: DW] = 8'hFF;
    zt  = '0;

    reset          = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.advance    = 1'b1;
    tick();
    tick();
    chk("rst_ready", 64'(bus.load_ready), 64'(1));
    idle_chk("rst");
    reset = 1'b0;
    tick();
    idle_chk("post_rst");

    // Single tile, constant advance.
    load_tile("t1", ta);
    stream_tile("t1", ta, -1, 0, 1'b0, zt, 1'b0, zt, -1, 9, 3, 8'h36);
    idle_chk("t1_end");

    // Second tile accepted while the first streams; no bubble between them.
    load_tile("t2", ta);
    stream_tile("t2a", ta, -1, 0, 1'b1, tbb, 1'b0, zt, -1, 0, 0, 8'h00);
    stream_tile("t2b", tbb, -1, 0, 1'b0, zt, 1'b0, zt, -1, 3, 3, 8'h38);
    idle_chk("t2_end");

    // Three-cycle stall at cnt=4.
    load_tile("t3", tc);
    stream_tile("t3", tc, 4, 3, 1'b0, zt, 1'b0, zt, -1, 4, 2, 8'h62);
    idle_chk("t3_end");

    // Third tile held off while the shadow is full; all three must arrive intact.
    load_tile("t4", ta);
    stream_tile("t4a", ta, -1, 0, 1'b1, tbb, 1'b1, tc, -1, -1, 0, 0);
    stream_tile("t4b", tbb, -1, 0, 1'b1, tc, 1'b0, zt, -1, -1, 0, 0);
    stream_tile("t4c", tc, -1, 0, 1'b0, zt, 1'b0, zt, -1, 6, 0, 8'h46);
    idle_chk("t4_end");

    // Reset at cnt=5 with a pending shadow tile: both tiles dropped.
    load_tile("t5", ta);
    stream_tile("t5", ta, -1, 0, 1'b1, tbb, 1'b0, zt, 5, -1, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      idle_chk($sformatf("t5_after%0d", i));
      chk($sformatf("t5_after%0d_ready", i), 64'(bus.load_ready), 64'(1));
    end

    // Negative elements pass through unchanged.
    load_tile("t6", td);
    stream_tile("t6a", td, -1, 0, 1'b0, zt, 1'b0, zt, -1, 0, 0, -128);
    idle_chk("t6a_end");
    load_tile("t6b", td);
    stream_tile("t6b", td, -1, 0, 1'b0, zt, 1'b0, zt, -1, 7, 1, -1);
    idle_chk("t6b_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/skewed_feeder.md
SKEWED_FEEDER -- requirements
Module: skewed_feeder

Interface
REQ-001 The module SHALL provide parameter N_CH, default 4, number of output channels (systolic array rows).
REQ-002 The module SHALL provide parameter DEPTH, default 7, elements per channel per tile.
REQ-003 The module SHALL provide parameter DW, default 8, element width in bits.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 load_valid  input  1  tile offered on load_data.
REQ-007 load_ready  output  1  shadow buffer empty, tile accepted when load_valid&&load_ready.
REQ-008 load_data  input  N_CH*DEPTH*DW  tile; element k of channel r at bits [(r*DEPTH+k)*DW +: DW].
REQ-009 advance  input  1  stream step enable; low = stall.
REQ-010 data_out  output  N_CH*DW signed  channel r element at bits [r*DW +: DW].
REQ-011 out_valid  output  N_CH  per-channel element-valid flag.
REQ-012 busy  output  1  high while state is STREAM.
REQ-013 done  output  1  one-cycle pulse on the final advancing beat of a tile.

Function
REQ-014 Storage SHALL be double-buffered: a shadow buffer plus a flag (shadow_full), and an active buffer.
REQ-015 On an accepted load, the shadow buffer SHALL capture load_data and set shadow_full; load_ready SHALL equal !shadow_full.
REQ-016 The FSM SHALL have states IDLE and STREAM, with beat counter cnt ranging 0..DEPTH+N_CH-2.
REQ-017 In IDLE with shadow_full=1, the next edge SHALL copy shadow to active, clear shadow_full, set cnt=0 and enter STREAM, independent of advance.
REQ-018 In STREAM, when advance=1 and cnt<DEPTH+N_CH-2, cnt SHALL increment; when advance=0, cnt, buffers and outputs SHALL hold.
REQ-019 In STREAM, when advance=1 and cnt=DEPTH+N_CH-2, done SHALL pulse that cycle; if shadow_full=1, shadow SHALL transfer to active, cnt=0, state stays STREAM (zero-bubble back-to-back); otherwise state SHALL go to IDLE.
REQ-020 Skew: in STREAM, channel r SHALL drive active element k=cnt-r with out_valid[r]=1 when 0<=cnt-r<DEPTH; otherwise data_out slice=0 and out_valid[r]=0.
REQ-021 In IDLE, all data_out SHALL be 0 and out_valid all 0.
REQ-022 data_out/out_valid SHALL be functions of registered state only (no combinational path from any input).
REQ-023 A load accepted in the same edge as a shadow-to-active transfer SHALL NOT occur (load_ready low while shadow_full); a load accepted in the cycle after a transfer SHALL be legal.
REQ-024 Element data SHALL pass unmodified (no sign extension or arithmetic); out_valid timing alone encodes the skew.
REQ-025 Total tile duration SHALL be DEPTH+N_CH-1 advancing beats; first output appears the cycle after the transfer edge.

Reset
REQ-026 Reset SHALL force state=IDLE, cnt=0, shadow_full=0, both buffers to 0, done=0, busy=0, data_out=0, out_valid=0, load_ready=1.
REQ-027 Reset asserted mid-STREAM SHALL discard both active and pending shadow tiles; no done pulse SHALL be emitted.

Structure
REQ-028 Package systolic_pkg SHALL hold the FSM state enum (feeder_state_t) and default N_CH/DEPTH/DW constants shared with the array.
REQ-029 One sub-module, feeder_lane, SHALL implement per-channel active storage and the skewed element mux (index cnt-r, zero outside window), instantiated N_CH times via generate.
REQ-030 cnt width SHALL be $clog2(DEPTH+N_CH-1), with a minimum of 1 bit.

Verification (N_CH=4, DEPTH=7, DW=8)
REQ-031 Load tile element(r,k)=16*r+k, advance=1 constantly -> ch0 outputs 0x00..0x06 on beats 0-6, ch3 outputs 0x30..0x36 on beats 3-9, done pulses on beat 9, then IDLE.
REQ-032 Two tiles loaded back-to-back (second accepted during streaming) -> second tile beat 0 directly follows first tile beat 9, no bubble, done pulses twice.
REQ-033 advance=0 for 3 cycles at cnt=4 -> all outputs held constant for 3 cycles, tile finishes 3 cycles later; done still single pulse.
REQ-034 Shadow full and third load_valid asserted -> load_ready=0 and third tile not captured until transfer; data integrity of all tiles checked.
REQ-035 Reset asserted at cnt=5 with shadow full -> next cycle all outputs 0, load_ready=1, busy=0, no done; a new tile then streams correctly.
REQ-036 Negative elements (0x80, 0xFF) -> appear unmodified, data_out interpreted as signed -128/-1.
